// File: rtl/pkg_func_eval_unit.sv
// Call engine: result = arg1 + arg2 + sum(local[i]), first result NUM_LOCALS+1 cycles after accept, held until rsp_ready.
// One call at a time, no request queueing. Define PFE_LOCAL_WRITE_EN to make the locals writable through the cfg_* port.
module pkg_func_eval_unit #(
  parameter int WIDTH      = 32,
  parameter int NUM_LOCALS = 3,
  parameter int INIT_BASE  = 1,
  localparam int IW        = $clog2(NUM_LOCALS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_arg1,
  input  logic [WIDTH-1:0] req_arg2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy,
  output logic [15:0]      call_count
`ifdef PFE_LOCAL_WRITE_EN
  ,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic             cfg_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] locals [NUM_LOCALS];
  logic             accept;
  logic             rsp_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (idx == IW'(NUM_LOCALS - 1)) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign accept     = req_valid && req_ready;
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign rsp_result = acc;

  // acc is frozen in RESP, so the result stays stable under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      idx        <= '0;
      call_count <= '0;
    end else begin
      if (accept) begin
        acc <= req_arg1 + req_arg2;
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= acc + locals[idx];
        idx <= idx + 1'b1;
      end
      if (rsp_hs && call_count != 16'hFFFF) call_count <= call_count + 16'd1;
    end
  end

`ifdef PFE_LOCAL_WRITE_EN
  logic addr_ok;
  assign addr_ok = 32'(cfg_addr) < NUM_LOCALS;

  // A write landing on the accept edge is seen by that call: locals are read from ACCUM onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LOCALS; i++) locals[i] <= WIDTH'(INIT_BASE + i);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (busy || !addr_ok);
      if (cfg_we && !busy && addr_ok) locals[cfg_addr] <= cfg_wdata;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_LOCALS; i++) locals[i] = WIDTH'(INIT_BASE + i);
  end
`endif

endmodule

// File: tb/tb_pkg_func_eval_unit.sv
// Directed bench for pkg_func_eval_unit: abstract call/response model compared every cycle, plus literal checks.
module tb_pkg_func_eval_unit;
  localparam int W = 32;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] a1 = '0, a2 = '0;
  logic         req_ready, rsp_valid, busy;
  logic [W-1:0] rsp_result;
  logic [15:0]  call_count;

  logic         v8 = 1'b0;
  logic [7:0]   x8 = '0, y8 = '0;
  logic         rdy8, vld8, busy8;
  logic [7:0]   res8;
  logic [15:0]  cnt8;

`ifdef PFE_LOCAL_WRITE_EN
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [W-1:0] cfg_wdata = '0;
  logic         cfg_err;
  logic         cfg_we8 = 1'b0;
  logic [1:0]   cfg_addr8 = '0;
  logic [7:0]   cfg_wdata8 = '0;
  logic         cfg_err8;
`endif

  always #5 clk = ~clk;

  pkg_func_eval_unit u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_arg1(a1), .req_arg2(a2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .busy(busy), .call_count(call_count)
`ifdef PFE_LOCAL_WRITE_EN
    , .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err)
`endif
  );

  pkg_func_eval_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(v8), .req_ready(rdy8),
    .req_arg1(x8), .req_arg2(y8), .rsp_valid(vld8), .rsp_ready(1'b1),
    .rsp_result(res8), .busy(busy8), .call_count(cnt8)
`ifdef PFE_LOCAL_WRITE_EN
    , .cfg_we(cfg_we8), .cfg_addr(cfg_addr8), .cfg_wdata(cfg_wdata8), .cfg_err(cfg_err8)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = free, 1 = computing, 2 = result offered
  int           m_phase = 0;
  int           m_left = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_loc [N];
  bit           m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_cnt = 0; m_res = '0; m_err = 1'b0;
      for (int i = 0; i < N; i++) m_loc[i] = W'(1 + i);
    end else begin
`ifdef PFE_LOCAL_WRITE_EN
      m_err = cfg_we && (m_phase != 0 || cfg_addr >= N);
      if (cfg_we && m_phase == 0 && cfg_addr < N) m_loc[cfg_addr] = cfg_wdata;
`endif
      case (m_phase)
        0: if (req_valid) begin
          m_res = a1 + a2;
          for (int i = 0; i < N; i++) m_res = m_res + m_loc[i];
          m_left = N;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (rsp_ready) begin
          m_phase = 0;
          if (m_cnt < 65535) m_cnt++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, m_phase == 0);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    chk("busy", busy, m_phase != 0);
    chk("call_count", call_count, m_cnt);
    if (m_phase == 2) chk("rsp_result", rsp_result, m_res);
`ifdef PFE_LOCAL_WRITE_EN
    chk("cfg_err", cfg_err, m_err);
`endif
  end

  task automatic do_call(input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1; req_valid = 1'b1; a1 = x; a2 = y;
    @(posedge clk); #1; req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [W-1:0] exp);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (seen) chk(name, rsp_result, exp);
    else begin
      n_chk++; n_fail++;
      $display("FAIL %s: rsp_valid never rose within 20 cycles, expected result %0d", name, exp);
    end
  endtask

  int           hs_cyc[$];
  logic [W-1:0] hs_res[$];
  bit           seen8;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_call_count", call_count, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // (5,7): 5+7+1+2+3 = 18, valid on the 4th cycle after the accept edge
    do_call(5, 7);
    repeat (3) @(negedge clk);
    chk("t1_not_yet_valid", rsp_valid, 0);
    @(negedge clk);
    chk("t1_valid_cycle4", rsp_valid, 1);
    chk("t1_result", rsp_result, 18);
    @(negedge clk);
    chk("t1_call_count", call_count, 1);

    // Backpressure: hold for 10 cycles, new requests ignored
    rsp_ready = 1'b0;
    do_call(5, 7);
    wait_rsp("stall_first", 18);
    req_valid = 1'b1; a1 = 9; a2 = 9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_result", rsp_result, 18);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clk); #1; req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_call_count", call_count, 2);

    // Back-to-back (1,1),(2,2): 8 then 10, handshakes 5 cycles apart
    @(posedge clk); #1; req_valid = 1'b1; a1 = 1; a2 = 1;
    @(posedge clk); #1; a1 = 2; a2 = 2;
    for (int c = 0; c < 40 && hs_cyc.size() < 2; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        hs_cyc.push_back(c);
        hs_res.push_back(rsp_result);
        if (hs_cyc.size() == 2) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    if (hs_cyc.size() < 2) begin
      n_chk++; n_fail++;
      $display("FAIL b2b_timeout: got %0d responses, expected 2", hs_cyc.size());
    end else begin
      chk("b2b_first", hs_res[0], 8);
      chk("b2b_second", hs_res[1], 10);
      chk("b2b_period", hs_cyc[1] - hs_cyc[0], N + 2);
    end

    // Reset during ACCUM
    do_call(5, 7);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_call_count", call_count, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    do_call(0, 0);
    wait_rsp("midrst_new_call", 6);

`ifdef PFE_LOCAL_WRITE_EN
    @(posedge clk); #1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 100;
    @(posedge clk); #1; cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_idle_no_err", cfg_err, 0);
    do_call(0, 0);
    wait_rsp("cfg_write_result", 104);

    do_call(0, 0);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 50;
    @(posedge clk); #1; cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_busy_err", cfg_err, 1);
    @(negedge clk);
    chk("cfg_err_pulse_end", cfg_err, 0);
    wait_rsp("cfg_busy_dropped", 104);

    @(posedge clk); #1; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 7;
    @(posedge clk); #1; cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_range_err", cfg_err, 1);

    // Write on the accept edge: 0+10+100+3 = 113
    @(posedge clk); #1; req_valid = 1'b1; a1 = 0; a2 = 0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 10;
    @(posedge clk); #1; req_valid = 1'b0; cfg_we = 1'b0;
    wait_rsp("cfg_same_cycle", 113);
`endif

    // WIDTH=8: 250+3+1+2+3 = 259 wraps to 3
    @(posedge clk); #1; v8 = 1'b1; x8 = 8'd250; y8 = 8'd3;
    @(posedge clk); #1; v8 = 1'b0;
    seen8 = 1'b0;
    for (int k = 0; k < 20 && !seen8; k++) begin
      @(negedge clk);
      if (vld8) seen8 = 1'b1;
    end
    if (seen8) chk("w8_wrap_result", res8, 3);
    else begin
      n_chk++; n_fail++;
      $display("FAIL w8_timeout: rsp_valid never rose, expected result 3");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
